// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline stage
interface id_ex_stage_if;
  logic        hold_i;
  logic        flush_i;
  logic        valid_i;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic [4:0]  RDaddr_i;
  logic        UseRS_i;
  logic        UseRT_i;
  logic [31:0] RSdata_i;
  logic [31:0] RTdata_i;
  logic [31:0] imm_i;
  logic        RegWrite_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic        MemtoReg_i;
  logic        ALUSrc_i;
  logic [1:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic        WB_RegWrite_i;
  logic [4:0]  WB_RDaddr_i;
  logic [31:0] WB_RDdata_i;
  logic        stall_o;
  logic        valid_o;
  logic [4:0]  RSaddr_o;
  logic [4:0]  RTaddr_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] RSdata_o;
  logic [31:0] RTdata_o;
  logic [31:0] imm_o;
  logic        RegWrite_o;
  logic        MemRead_o;
  logic        MemWrite_o;
  logic        MemtoReg_o;
  logic        ALUSrc_o;
  logic [1:0]  ALUOp_o;
  logic [5:0]  funct_o;
  modport master (
    output hold_i, flush_i, valid_i, RSaddr_i, RTaddr_i, RDaddr_i, UseRS_i, UseRT_i,
           RSdata_i, RTdata_i, imm_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
           ALUSrc_i, ALUOp_i, funct_i, WB_RegWrite_i, WB_RDaddr_i, WB_RDdata_i,
    input  stall_o, valid_o, RSaddr_o, RTaddr_o, RDaddr_o, RSdata_o, RTdata_o, imm_o,
           RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, ALUOp_o, funct_o
  );
  modport slave (
    input  hold_i, flush_i, valid_i, RSaddr_i, RTaddr_i, RDaddr_i, UseRS_i, UseRT_i,
           RSdata_i, RTdata_i, imm_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
           ALUSrc_i, ALUOp_i, funct_i, WB_RegWrite_i, WB_RDaddr_i, WB_RDdata_i,
    output stall_o, valid_o, RSaddr_o, RTaddr_o, RDaddr_o, RSdata_o, RTdata_o, imm_o,
           RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, ALUOp_o, funct_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with load-use stall, WB bypass, flush bubbles and hold
module id_ex_stage (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
  } ex_t;
  ex_t  ex_q, ex_d, id_w;
  logic flush_pend_q, flush_pend_d;
  logic stall;
  logic bubble;
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    return (a == 5'd0) ? 32'd0 : (bus.WB_RegWrite_i && bus.WB_RDaddr_i == a) ? bus.WB_RDdata_i : rf;
  endfunction
  assign stall = bus.valid_i & ex_q.valid & ex_q.mem_read & (|ex_q.rd_addr) &
                 ((bus.UseRS_i & (bus.RSaddr_i == ex_q.rd_addr)) |
                  (bus.UseRT_i & (bus.RTaddr_i == ex_q.rd_addr))) &
                 ~bus.hold_i & ~bus.flush_i;
  assign bubble = bus.flush_i | flush_pend_q | stall | ~bus.valid_i;
  assign id_w = '{
    valid:      1'b1,
    rs_addr:    bus.RSaddr_i,
    rt_addr:    bus.RTaddr_i,
    rd_addr:    bus.RDaddr_i,
    rs_data:    operand(bus.RSaddr_i, bus.RSdata_i),
    rt_data:    operand(bus.RTaddr_i, bus.RTdata_i),
    imm:        bus.imm_i,
    reg_write:  bus.RegWrite_i,
    mem_read:   bus.MemRead_i,
    mem_write:  bus.MemWrite_i,
    mem_to_reg: bus.MemtoReg_i,
    alu_src:    bus.ALUSrc_i,
    alu_op:     bus.ALUOp_i,
    funct:      bus.funct_i
  };
  // Hold freezes everything and only remembers a flush; otherwise load a bubble or the ID instruction
  always_comb begin
    ex_d = bus.hold_i ? ex_q : bubble ? '0 : id_w;
    flush_pend_d = bus.hold_i & (flush_pend_q | bus.flush_i);
  end
  // EX-side pipeline register and sticky flush flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      ex_q <= ex_d;
      flush_pend_q <= flush_pend_d;
    end
  end
  assign bus.stall_o    = stall;
  assign bus.valid_o    = ex_q.valid;
  assign bus.RSaddr_o   = ex_q.rs_addr;
  assign bus.RTaddr_o   = ex_q.rt_addr;
  assign bus.RDaddr_o   = ex_q.rd_addr;
  assign bus.RSdata_o   = ex_q.rs_data;
  assign bus.RTdata_o   = ex_q.rt_data;
  assign bus.imm_o      = ex_q.imm;
  assign bus.RegWrite_o = ex_q.reg_write;
  assign bus.MemRead_o  = ex_q.mem_read;
  assign bus.MemWrite_o = ex_q.mem_write;
  assign bus.MemtoReg_o = ex_q.mem_to_reg;
  assign bus.ALUSrc_o   = ex_q.alu_src;
  assign bus.ALUOp_o    = ex_q.alu_op;
  assign bus.funct_o    = ex_q.funct;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed checking of id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  id_ex_stage_if bus ();
  id_ex_stage dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rsa, rta, rda;
    logic [31:0] rsd, rtd, imm;
    logic        rw, mr, mw, m2r, asrc;
    logic [1:0]  aop;
    logic [5:0]  fn;
  } rec_t;
  rec_t m = '0;
  logic m_pend = 1'b0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 0;
    if (bus.WB_RegWrite_i && bus.WB_RDaddr_i == a) return bus.WB_RDdata_i;
    return rf;
  endfunction
  function automatic logic m_stall();
    logic uses_ld;
    if (bus.hold_i || bus.flush_i || !bus.valid_i) return 0;
    if (!(m.valid && m.mr) || m.rda == 0) return 0;
    uses_ld = (bus.UseRS_i && bus.RSaddr_i == m.rda) || (bus.UseRT_i && bus.RTaddr_i == m.rda);
    return uses_ld;
  endfunction
  function automatic rec_t incoming();
    rec_t r;
    r.valid = 1'b1;
    r.rsa = bus.RSaddr_i;
    r.rta = bus.RTaddr_i;
    r.rda = bus.RDaddr_i;
    r.rsd = opnd(bus.RSaddr_i, bus.RSdata_i);
    r.rtd = opnd(bus.RTaddr_i, bus.RTdata_i);
    r.imm = bus.imm_i;
    r.rw = bus.RegWrite_i;
    r.mr = bus.MemRead_i;
    r.mw = bus.MemWrite_i;
    r.m2r = bus.MemtoReg_i;
    r.asrc = bus.ALUSrc_i;
    r.aop = bus.ALUOp_i;
    r.fn = bus.funct_i;
    return r;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      m_pend <= 1'b0;
    end else if (bus.hold_i) begin
      m_pend <= m_pend | bus.flush_i;
    end else begin
      m <= (bus.flush_i || m_pend || m_stall() || !bus.valid_i) ? rec_t'('0) : incoming();
      m_pend <= 1'b0;
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      #1 chk("stall_o", bus.stall_o, m_stall());
      @(posedge clk);
      #1;
      chk("valid_o", bus.valid_o, m.valid);
      chk("RSaddr_o", bus.RSaddr_o, m.rsa);
      chk("RTaddr_o", bus.RTaddr_o, m.rta);
      chk("RDaddr_o", bus.RDaddr_o, m.rda);
      chk("RSdata_o", bus.RSdata_o, m.rsd);
      chk("RTdata_o", bus.RTdata_o, m.rtd);
      chk("imm_o", bus.imm_o, m.imm);
      chk("RegWrite_o", bus.RegWrite_o, m.rw);
      chk("MemRead_o", bus.MemRead_o, m.mr);
      chk("MemWrite_o", bus.MemWrite_o, m.mw);
      chk("MemtoReg_o", bus.MemtoReg_o, m.m2r);
      chk("ALUSrc_o", bus.ALUSrc_o, m.asrc);
      chk("ALUOp_o", bus.ALUOp_o, m.aop);
      chk("funct_o", bus.funct_o, m.fn);
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    {bus.hold_i, bus.flush_i, bus.valid_i, bus.UseRS_i, bus.UseRT_i} = '0;
    {bus.RSaddr_i, bus.RTaddr_i, bus.RDaddr_i} = '0;
    {bus.RSdata_i, bus.RTdata_i, bus.imm_i} = '0;
    {bus.RegWrite_i, bus.MemRead_i, bus.MemWrite_i, bus.MemtoReg_i, bus.ALUSrc_i} = '0;
    bus.ALUOp_i = '0;
    bus.funct_i = '0;
    bus.WB_RegWrite_i = 1'b0;
    bus.WB_RDaddr_i = '0;
    bus.WB_RDdata_i = '0;
  endtask
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic mr, input logic rw,
                        input logic [5:0] fn);
    bus.valid_i = 1'b1;
    bus.RSaddr_i = rs;
    bus.RTaddr_i = rt;
    bus.RDaddr_i = rd;
    bus.UseRS_i = urs;
    bus.UseRT_i = urt;
    bus.RSdata_i = 32'h100 + 32'(rs);
    bus.RTdata_i = 32'h200 + 32'(rt);
    bus.imm_i = 32'h10;
    bus.MemRead_i = mr;
    bus.MemtoReg_i = mr;
    bus.ALUSrc_i = mr;
    bus.RegWrite_i = rw;
    bus.MemWrite_i = 1'b0;
    bus.ALUOp_i = mr ? 2'd0 : 2'd2;
    bus.funct_i = fn;
  endtask
  task automatic rand_inputs();
    bus.hold_i = ($urandom_range(0, 7) == 0);
    bus.flush_i = ($urandom_range(0, 7) == 0);
    bus.valid_i = ($urandom_range(0, 5) != 0);
    bus.RSaddr_i = 5'($urandom_range(0, 7));
    bus.RTaddr_i = 5'($urandom_range(0, 7));
    bus.RDaddr_i = 5'($urandom_range(0, 7));
    bus.UseRS_i = 1'($urandom_range(0, 1));
    bus.UseRT_i = 1'($urandom_range(0, 1));
    bus.RSdata_i = $urandom;
    bus.RTdata_i = $urandom;
    bus.imm_i = $urandom;
    bus.RegWrite_i = 1'($urandom_range(0, 1));
    bus.MemRead_i = 1'($urandom_range(0, 1));
    bus.MemWrite_i = 1'($urandom_range(0, 1));
    bus.MemtoReg_i = 1'($urandom_range(0, 1));
    bus.ALUSrc_i = 1'($urandom_range(0, 1));
    bus.ALUOp_i = 2'($urandom_range(0, 3));
    bus.funct_i = 6'($urandom_range(0, 63));
    bus.WB_RegWrite_i = 1'($urandom_range(0, 1));
    bus.WB_RDaddr_i = 5'($urandom_range(0, 7));
    bus.WB_RDdata_i = $urandom;
  endtask
  initial begin
    idle();
    set_id(3, 4, 5, 1, 1, 1, 1, 6'h2a);
    bus.RSdata_i = 32'h11;
    step();
    step();
    chk("rst valid_o", bus.valid_o, 0);
    chk("rst MemRead_o", bus.MemRead_o, 0);
    chk("rst RSdata_o", bus.RSdata_o, 0);
    chk("rst funct_o", bus.funct_o, 0);
    chk("rst stall_o", bus.stall_o, 0);
    rst_n = 1'b1;
    idle();
    set_id(3, 0, 0, 1, 0, 0, 0, 0);
    bus.RSdata_i = 32'h11;
    step();
    chk("first RSdata_o", bus.RSdata_o, 32'h11);
    chk("first valid_o", bus.valid_o, 1);
    set_id(1, 0, 5, 1, 0, 1, 1, 0);
    step();
    chk("lw MemRead_o", bus.MemRead_o, 1);
    set_id(5, 6, 7, 1, 1, 0, 1, 6'h20);
    #1 chk("loaduse stall_o", bus.stall_o, 1);
    step();
    chk("loaduse bubble valid_o", bus.valid_o, 0);
    chk("loaduse bubble RegWrite_o", bus.RegWrite_o, 0);
    chk("loaduse bubble MemRead_o", bus.MemRead_o, 0);
    chk("loaduse stall released", bus.stall_o, 0);
    step();
    chk("add enters valid_o", bus.valid_o, 1);
    chk("add enters funct_o", bus.funct_o, 6'h20);
    set_id(1, 0, 5, 1, 0, 1, 1, 0);
    step();
    set_id(2, 5, 7, 1, 0, 0, 1, 6'h20);
    #1 chk("rt unused stall_o", bus.stall_o, 0);
    step();
    chk("rt unused RTaddr_o", bus.RTaddr_o, 5);
    chk("rt unused valid_o", bus.valid_o, 1);
    set_id(1, 0, 0, 1, 0, 1, 1, 0);
    step();
    set_id(0, 0, 3, 1, 1, 0, 1, 6'h20);
    bus.RSdata_i = 32'hdeadbeef;
    #1 chk("r0 stall_o", bus.stall_o, 0);
    step();
    chk("r0 RSdata_o", bus.RSdata_o, 0);
    set_id(4, 7, 8, 1, 1, 0, 1, 6'h21);
    bus.RTdata_i = 32'h1;
    bus.WB_RegWrite_i = 1'b1;
    bus.WB_RDaddr_i = 7;
    bus.WB_RDdata_i = 32'hcafef00d;
    step();
    chk("bypass RTdata_o", bus.RTdata_o, 32'hcafef00d);
    bus.WB_RDaddr_i = 0;
    step();
    chk("no bypass RTdata_o", bus.RTdata_o, 32'h1);
    idle();
    set_id(2, 3, 4, 1, 1, 0, 1, 6'h20);
    bus.flush_i = 1'b1;
    step();
    chk("flush valid_o", bus.valid_o, 0);
    chk("flush RegWrite_o", bus.RegWrite_o, 0);
    bus.flush_i = 1'b0;
    set_id(1, 0, 5, 1, 0, 1, 1, 0);
    step();
    set_id(5, 6, 7, 1, 1, 0, 1, 6'h20);
    bus.flush_i = 1'b1;
    #1 chk("flush+stall stall_o", bus.stall_o, 0);
    step();
    chk("flush+stall valid_o", bus.valid_o, 0);
    bus.flush_i = 1'b0;
    #1 chk("after flush stall_o", bus.stall_o, 0);
    step();
    chk("after flush valid_o", bus.valid_o, 1);
    set_id(1, 2, 9, 1, 1, 0, 1, 6'h22);
    step();
    chk("pre-hold funct_o", bus.funct_o, 6'h22);
    bus.hold_i = 1'b1;
    set_id(3, 4, 10, 1, 1, 0, 1, 6'h24);
    step();
    chk("hold1 funct_o", bus.funct_o, 6'h22);
    bus.flush_i = 1'b1;
    step();
    chk("hold2 funct_o", bus.funct_o, 6'h22);
    bus.flush_i = 1'b0;
    step();
    chk("hold3 funct_o", bus.funct_o, 6'h22);
    chk("hold3 valid_o", bus.valid_o, 1);
    bus.hold_i = 1'b0;
    step();
    chk("pend bubble valid_o", bus.valid_o, 0);
    chk("pend bubble funct_o", bus.funct_o, 0);
    step();
    chk("post pend valid_o", bus.valid_o, 1);
    chk("post pend funct_o", bus.funct_o, 6'h24);
    set_id(1, 0, 5, 1, 0, 1, 1, 0);
    step();
    set_id(5, 6, 7, 1, 1, 0, 1, 6'h20);
    bus.hold_i = 1'b1;
    #1 chk("hold stall_o", bus.stall_o, 0);
    step();
    chk("hold keeps MemRead_o", bus.MemRead_o, 1);
    bus.hold_i = 1'b0;
    #1 chk("release stall_o", bus.stall_o, 1);
    step();
    chk("release bubble valid_o", bus.valid_o, 0);
    for (int i = 0; i < 2000; i++) begin
      rand_inputs();
      step();
      if (i == 1000) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async rst valid_o", bus.valid_o, 0);
        chk("async rst RDaddr_o", bus.RDaddr_o, 0);
        chk("async rst imm_o", bus.imm_o, 0);
        chk("async rst stall_o", bus.stall_o, 0);
        step();
        rst_n = 1'b1;
      end
    end
    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
